// File: rtl/hl_scan_sel.sv
// Registered N-channel word selector for the display path: manual channel
// select, or automatic rotation through the channels every DWELL cycles.
module hl_scan_sel #(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned DWELL    = 100000,
    localparam int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      MODE,
    input  logic [SEL_W-1:0]          SEL,
    input  logic                      HOLD,
    input  logic [CHANNELS*WIDTH-1:0] MUX_IN,
    output logic [WIDTH-1:0]          MUX_OUTPUT,
    output logic [SEL_W-1:0]          CH_OUT,
    output logic                      STEP
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               step_q, step_d;
    logic               sel_ok;
    logic               expired;

    assign sel_ok  = (32'(SEL) < CHANNELS);
    assign expired = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: HOLD freezes the mode, otherwise MODE picks the state
    always_comb begin
        state_d = state_q;
        if (!HOLD) begin
            state_d = MODE ? ST_SCAN : ST_MANUAL;
        end
    end

    // Channel, dwell counter, step pulse and data next values
    always_comb begin
        ch_d   = ch_q;
        cnt_d  = cnt_q;
        step_d = 1'b0;
        data_d = data_q;
        if (!HOLD) begin
            case (state_q)
                ST_MANUAL: begin
                    cnt_d = '0;
                    if (!MODE && sel_ok) begin
                        ch_d = SEL;
                    end
                end
                ST_SCAN: begin
                    if (!MODE) begin
                        cnt_d = '0;
                        if (sel_ok) begin
                            ch_d = SEL;
                        end
                    end else if (expired) begin
                        cnt_d  = '0;
                        ch_d   = (ch_q == CH_LAST) ? '0 : ch_q + SEL_W'(1);
                        step_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
            // Sample the word of the channel about to be shown
            for (int k = 0; k < int'(CHANNELS); k++) begin
                if (ch_d == SEL_W'(k)) begin
                    data_d = MUX_IN[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            ch_q   <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            step_q <= 1'b0;
        end else begin
            ch_q   <= ch_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            step_q <= step_d;
        end
    end

    assign MUX_OUTPUT = data_q;
    assign CH_OUT     = ch_q;
    assign STEP       = step_q;

endmodule

// File: tb/tb_hl_scan_sel.sv
// Bench for hl_scan_sel: default configuration (4 ch, dwell 3) and an edge
// configuration (3 ch, dwell 1), checked every cycle against a dwell-time model.
module tb_hl_scan_sel;

    localparam int unsigned W  = 8;
    localparam int unsigned NA = 4;
    localparam int unsigned DA = 3;
    localparam int unsigned NB = 3;
    localparam int unsigned DB = 1;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic            rst_a, mode_a, hold_a, step_a;
    logic [1:0]      sel_a, ch_a;
    logic [NA*W-1:0] in_a;
    logic [W-1:0]    out_a;

    logic            rst_b, mode_b, hold_b, step_b;
    logic [1:0]      sel_b, ch_b;
    logic [NB*W-1:0] in_b;
    logic [W-1:0]    out_b;

    hl_scan_sel #(.WIDTH(W), .CHANNELS(NA), .DWELL(DA)) dut_a (
        .CLK(CLK), .RST(rst_a), .MODE(mode_a), .SEL(sel_a), .HOLD(hold_a),
        .MUX_IN(in_a), .MUX_OUTPUT(out_a), .CH_OUT(ch_a), .STEP(step_a)
    );

    hl_scan_sel #(.WIDTH(W), .CHANNELS(NB), .DWELL(DB)) dut_b (
        .CLK(CLK), .RST(rst_b), .MODE(mode_b), .SEL(sel_b), .HOLD(hold_b),
        .MUX_IN(in_b), .MUX_OUTPUT(out_b), .CH_OUT(ch_b), .STEP(step_b)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: in scan, shown channel = start + (scan edges since entry) / dwell
    int m_scan[2], m_ch[2], m_start[2], m_el[2], m_data[2], m_step[2];

    task automatic model_edge(input int d, input int n, input int dw,
                              input logic rst, input logic mode, input logic hold,
                              input int sel, input logic [31:0] mux);
        if (rst) begin
            m_scan[d] = 0; m_ch[d] = 0; m_start[d] = 0; m_el[d] = 0;
            m_data[d] = 0; m_step[d] = 0;
            return;
        end
        m_step[d] = 0;
        if (hold) return;
        if (m_scan[d] != 0 && mode) begin
            m_el[d]++;
            m_ch[d]   = (m_start[d] + m_el[d] / dw) % n;
            m_step[d] = (m_el[d] % dw == 0) ? 1 : 0;
        end else if (m_scan[d] == 0 && mode) begin
            m_scan[d]  = 1;
            m_start[d] = m_ch[d];
            m_el[d]    = 0;
        end else begin
            m_scan[d] = 0;
            if (sel < n) m_ch[d] = sel;
        end
        m_data[d] = int'((mux >> (m_ch[d] * 8)) & 32'hFF);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge(0, NA, DA, rst_a, mode_a, hold_a, int'(sel_a), 32'(in_a));
        model_edge(1, NB, DB, rst_b, mode_b, hold_b, int'(sel_b), 32'(in_b));
        #1;
        chk("a_data", int'(out_a), m_data[0]);
        chk("a_ch",   int'(ch_a),  m_ch[0]);
        chk("a_step", int'(step_a), m_step[0]);
        chk("b_data", int'(out_b), m_data[1]);
        chk("b_ch",   int'(ch_b),  m_ch[1]);
        chk("b_step", int'(step_b), m_step[1]);
    endtask

    initial begin
        rst_a = 1'b1; mode_a = 1'b0; hold_a = 1'b0; sel_a = 2'd0; in_a = 32'h44332211;
        rst_b = 1'b1; mode_b = 1'b0; hold_b = 1'b0; sel_b = 2'd0; in_b = 24'hCCBBAA;

        // Reset
        repeat (2) tick();
        chk("rst_data", int'(out_a), 0);
        chk("rst_ch", int'(ch_a), 0);
        chk("rst_step", int'(step_a), 0);
        rst_a = 1'b0;
        tick();
        chk("rel_data", int'(out_a), 'h11);

        // Manual select and data follow
        sel_a = 2'd2;
        tick();
        chk("man_ch", int'(ch_a), 2);
        chk("man_data", int'(out_a), 'h33);
        in_a[23:16] = 8'hA5;
        tick();
        chk("man_follow", int'(out_a), 'hA5);
        in_a[23:16] = 8'h33;
        sel_a = 2'd0;
        tick();

        // Scan from ch0: 13 cycles
        mode_a = 1'b1;
        repeat (13) tick();
        // Advance to ch1 with one dwell cycle already elapsed
        repeat (4) tick();
        chk("pre_hold_ch", int'(ch_a), 1);

        // HOLD mid-dwell while MUX_IN churns
        hold_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_a = $urandom;
            sel_a = 2'($urandom);
            tick();
        end
        in_a = 32'h44332211;
        hold_a = 1'b0;
        tick();
        chk("hold_rel_ch", int'(ch_a), 1);
        tick();
        chk("hold_exp_ch", int'(ch_a), 2);
        chk("hold_exp_step", int'(step_a), 1);

        // Reset mid-scan with MODE held
        rst_a = 1'b1;
        tick();
        chk("midrst_data", int'(out_a), 0);
        rst_a = 1'b0;
        repeat (7) tick();

        // Edge configuration: out-of-range SEL, then dwell-1 scan
        rst_b = 1'b0; sel_b = 2'd1;
        tick();
        sel_b = 2'd3;
        tick();
        chk("b_oor_ch", int'(ch_b), 1);
        sel_b = 2'd0;
        tick();
        mode_b = 1'b1;
        repeat (6) tick();

        // Randomized phase on both instances
        for (int i = 0; i < 800; i++) begin
            rst_a  = ($urandom_range(0, 59) == 0);
            rst_b  = ($urandom_range(0, 59) == 0);
            hold_a = ($urandom_range(0, 5) == 0);
            hold_b = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) mode_a = ~mode_a;
            if ($urandom_range(0, 19) == 0) mode_b = ~mode_b;
            sel_a = 2'($urandom);
            sel_b = 2'($urandom);
            if ($urandom_range(0, 3) == 0) in_a = $urandom;
            if ($urandom_range(0, 3) == 0) in_b = 24'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
